square_ctl: RTL
===============

SQUARE_CTL -- requirements
Module: square_ctl

Interface
REQ-001 The block SHALL have the parameter H_MAX, default 1023, meaning the last valid pixel column of the board area.
REQ-002 The block SHALL have the parameter V_MAX, default 767, meaning the last valid pixel row of the board area.
REQ-003 pclk  input  1  pixel clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously to pclk.
REQ-005 mouse_xpos  input  12  cursor column, already in the pclk domain.
REQ-006 mouse_ypos  input  12  cursor row, already in the pclk domain.
REQ-007 mouse_left  input  1  left button level, already in the pclk domain.
REQ-008 start_en  input  1  game running.
REQ-009 choice_en  input  1  colour-choice menu active.
REQ-010 first_color  input  1  colour of the first mover: 0 = blue, 1 = yellow.
REQ-011 restart  input  1  single-cycle pulse that clears the board and begins a new game.
REQ-012 square  output  9  occupancy; bit k-1 drives squareK of the per-square draw stages.
REQ-013 square_color  output  9  per-square owner (0 = blue, 1 = yellow); valid only where the matching square bit is 1.
REQ-014 turn  output  1  colour of the player to move.
REQ-015 game_over  output  1  game finished.
REQ-016 winner  output  2  result: 00 = none, 01 = blue, 10 = yellow, 11 = draw.

Function
REQ-017 The grid SHALL be decoded from the cursor position as follows.
- Columns: x 0..338, 339..684, 685..H_MAX.
- Rows: y 0..258, 259..507, 508..V_MAX.
- Numbering: squares 1..3 top row, 4..6 middle row, 7..9 bottom row, left to right (square4 = x<=338, y 259..507).
REQ-018 A click SHALL be the cycle where mouse_left=1 and mouse_left registered on the previous cycle=0.
REQ-019 Clicks with x>H_MAX or y>V_MAX SHALL be ignored.
REQ-020 The FSM SHALL have four states: IDLE, PLAY, CHECK, OVER.
REQ-021 In any state, start_en=0 or choice_en=1 SHALL force IDLE on the next edge; the board contents are retained.
REQ-022 IDLE->PLAY SHALL occur when start_en=1 and choice_en=0; on that edge square and square_color clear, turn<=first_color, winner<=00.
REQ-023 A click in PLAY on an empty square SHALL, on the next edge:
- set that square bit;
- write turn into the matching square_color bit;
- move to CHECK.
REQ-024 A click in PLAY on an occupied square SHALL be ignored; the state stays PLAY and turn is unchanged.
REQ-025 CHECK SHALL evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) for three occupied squares of equal colour, in exactly one cycle.
REQ-026 CHECK exits SHALL be:
- line found -> OVER, winner = 01 or 10 per colour, game_over=1;
- else board full -> OVER, winner=11, game_over=1;
- else -> PLAY with turn toggled.
REQ-027 Clicks arriving in CHECK or OVER SHALL be ignored; they are not queued.
REQ-028 restart=1 while start_en=1 and choice_en=0 SHALL clear the board, set turn<=first_color and winner<=00, deassert game_over, and go to PLAY on the next edge, from any state.
REQ-029 restart in the same cycle as a click SHALL win; the click is discarded.
REQ-030 All outputs SHALL be registered.
REQ-031 Latency from click cycle to square bit visible SHALL be 1 cycle.
REQ-032 Latency from click cycle to game_over visible SHALL be 2 cycles.

Reset
REQ-033 rst=0 SHALL immediately set state IDLE, square=0, square_color=0, turn=0, game_over=0, winner=00, and clear the registered mouse_left.
REQ-034 rst asserted mid-game SHALL discard any pending CHECK.

Verification
REQ-035 Reset, start_en=1, choice_en=0, first_color=1, click at (100,300) -> square=9'b000001000, square_color[3]=1 one cycle later; turn=0 one cycle after that.
REQ-036 Second click on square4 -> square unchanged; turn unchanged; state PLAY.
REQ-037 Blue clicks at squares 1,2,3 interleaved with yellow clicks at 4,5 -> winner=01 and game_over=1 two cycles after the click on square 3; a further click changes nothing.
REQ-038 Fill the board with no line -> winner=11 after the ninth click.
REQ-039 mouse_left held high for 50 cycles -> exactly one square claimed; click at (1100,100) -> ignored.
REQ-040 Mid-game choice_en=1 then 0 -> board cleared on re-entry to PLAY; restart coincident with a click -> board empty, turn=first_color.

Source files
------------

// File: rtl/square_ctl.sv
// Tic-tac-toe board controller: decodes mouse clicks into a 3x3 grid, alternates turns,
// and judges win/draw one cycle after each accepted move.
//
// state | meaning
// IDLE  | game not running or colour menu open; board contents held
// PLAY  | waiting for a click on an empty square
// CHECK | judging the board after the last move
// OVER  | result latched; clicks ignored until restart
module square_ctl #(
    parameter int H_MAX = 1023,
    parameter int V_MAX = 767
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    input  logic        first_color,
    input  logic        restart,
    output logic [8:0]  square,
    output logic [8:0]  square_color,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

    localparam logic [11:0] H_LIM = 12'(H_MAX);
    localparam logic [11:0] V_LIM = 12'(V_MAX);

    // Three-in-a-row masks: rows, columns, diagonals (bit k-1 = squareK)
    localparam logic [8:0] LINE_MASK [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    state_t     state_q, state_d;
    logic [8:0] square_q, square_d;
    logic [8:0] color_q, color_d;
    logic       turn_q, turn_d;
    logic       over_q, over_d;
    logic [1:0] winner_q, winner_d;
    logic       left_q;

    logic       click;
    logic       in_area;
    logic [2:0] col_oh, row_oh;
    logic [8:0] sel_oh;
    logic       win_b, win_y;

    assign click   = mouse_left & ~left_q;
    assign in_area = (mouse_xpos <= H_LIM) && (mouse_ypos <= V_LIM);

    always_comb begin
        col_oh = 3'b100;
        if (mouse_xpos <= 12'd338)      col_oh = 3'b001;
        else if (mouse_xpos <= 12'd684) col_oh = 3'b010;
        row_oh = 3'b100;
        if (mouse_ypos <= 12'd258)      row_oh = 3'b001;
        else if (mouse_ypos <= 12'd507) row_oh = 3'b010;
        sel_oh = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sel_oh[3*r+c] = row_oh[r] & col_oh[c];
            end
        end
    end

    always_comb begin
        win_b = 1'b0;
        win_y = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((square_q & LINE_MASK[i]) == LINE_MASK[i]) begin
                if ((color_q & LINE_MASK[i]) == LINE_MASK[i]) win_y = 1'b1;
                if ((color_q & LINE_MASK[i]) == 9'd0)         win_b = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        square_d = square_q;
        color_d  = color_q;
        turn_d   = turn_q;
        over_d   = over_q;
        winner_d = winner_q;
        if (!start_en || choice_en) begin
            state_d = IDLE;
        end else if (restart || state_q == IDLE) begin
            // Restart outranks any click arriving in the same cycle
            square_d = '0;
            color_d  = '0;
            turn_d   = first_color;
            over_d   = 1'b0;
            winner_d = 2'b00;
            state_d  = PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    if (click && in_area && ((square_q & sel_oh) == 9'd0)) begin
                        square_d = square_q | sel_oh;
                        color_d  = turn_q ? (color_q | sel_oh) : (color_q & ~sel_oh);
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (win_b || win_y) begin
                        winner_d = win_y ? 2'b10 : 2'b01;
                        over_d   = 1'b1;
                        state_d  = OVER;
                    end else if (&square_q) begin
                        winner_d = 2'b11;
                        over_d   = 1'b1;
                        state_d  = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            square_q <= '0;
            color_q  <= '0;
            turn_q   <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            square_q <= square_d;
            color_q  <= color_d;
            turn_q   <= turn_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            left_q   <= mouse_left;
        end
    end

    assign square       = square_q;
    assign square_color = color_q;
    assign turn         = turn_q;
    assign game_over    = over_q;
    assign winner       = winner_q;

endmodule
